// File: rtl/noise_pkg.sv
// Shared types and constants for the noise generator CDF table loader.
package noise_pkg;

  localparam int unsigned NOISE_DEPTH  = 128;
  localparam int unsigned NOISE_DATA_W = 64;
  localparam int unsigned NOISE_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } cdf_load_state_t;

  localparam logic [1:0] CDF_ERR_NONE    = 2'd0;
  localparam logic [1:0] CDF_ERR_MONO    = 2'd1;
  localparam logic [1:0] CDF_ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/noise_cdf_mono_check.sv
// Remembers the last accepted CDF word and flags an incoming word that is smaller.
module noise_cdf_mono_check #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  output logic              violation
);

  logic [DATA_W-1:0] prev_q, prev_d;

  // prev clears to zero on start, so word 0 can never be flagged
  assign violation = accept && (data < prev_q);

  always_comb begin
    prev_d = prev_q;
    if (clear) begin
      prev_d = '0;
    end else if (accept && !violation) begin
      prev_d = data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/noise_cdf_loader.sv
// Streams a DEPTH-entry CDF table into the noise_128 generator write port and waits for its ack.
// Define NOISE_CDF_MONO_CHECK_EN to enable the non-monotonic table check.
module noise_cdf_loader
  import noise_pkg::*;
#(
  parameter int unsigned DEPTH       = NOISE_DEPTH,
  parameter int unsigned DATA_W      = NOISE_DATA_W,
  parameter int unsigned ADDR_W      = NOISE_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              load_mem,
  output logic [ADDR_W-1:0] location,
  output logic [DATA_W-1:0] mem_data,
  input  logic              done_wait,
  output logic              busy,
  output logic              cdf_ready,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_index
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO = TMO_W'(ACK_TIMEOUT - 1);

  cdf_load_state_t   state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pad_q, pad_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              load_mem_q, load_mem_d;
  logic [ADDR_W-1:0] location_q, location_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              cdf_ready_q, cdf_ready_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_index_q, err_index_d;

  logic accept;
  logic start_ok;
  logic mono_viol;

  assign s_ready  = (state_q == ST_LOAD);
  assign accept   = s_valid && s_ready;
  assign start_ok = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

`ifdef NOISE_CDF_MONO_CHECK_EN
  noise_cdf_mono_check #(
    .DATA_W (DATA_W)
  ) u_mono_check (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (start_ok),
    .accept    (accept),
    .data      (s_data),
    .violation (mono_viol)
  );
`else
  assign mono_viol = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pad_d       = pad_q;
    tmo_d       = tmo_q;
    load_mem_d  = 1'b0;
    location_d  = location_q;
    mem_data_d  = mem_data_q;
    cdf_ready_d = cdf_ready_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          cdf_ready_d = 1'b0;
          err_d       = 1'b0;
          err_code_d  = CDF_ERR_NONE;
          err_index_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (mono_viol) begin
            state_d     = ST_ERROR;
            err_d       = 1'b1;
            err_code_d  = CDF_ERR_MONO;
            err_index_d = idx_q;
          end else begin
            load_mem_d = 1'b1;
            location_d = idx_q;
            mem_data_d = s_data;
            if (idx_q == LAST_IDX) begin
              state_d = ST_PAD;
              pad_d   = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      // two rewrites of the last entry so the generator's counter reaches DEPTH+1
      ST_PAD: begin
        load_mem_d = 1'b1;
        pad_d      = 1'b1;
        if (pad_q) begin
          state_d = ST_WAIT_ACK;
          tmo_d   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (done_wait) begin
          state_d     = ST_DONE;
          cdf_ready_d = 1'b1;
        end else if (tmo_q == LAST_TMO) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = CDF_ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d inside {ST_LOAD, ST_PAD, ST_WAIT_ACK});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pad_q       <= 1'b0;
      tmo_q       <= '0;
      load_mem_q  <= 1'b0;
      location_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      cdf_ready_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= CDF_ERR_NONE;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pad_q       <= pad_d;
      tmo_q       <= tmo_d;
      load_mem_q  <= load_mem_d;
      location_q  <= location_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      cdf_ready_q <= cdf_ready_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
    end
  end

  assign load_mem  = load_mem_q;
  assign location  = location_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign cdf_ready = cdf_ready_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_noise_cdf_loader.sv
// Self-checking bench for noise_cdf_loader: behavioural model compared every cycle plus literal checks.
module tb_noise_cdf_loader;
  localparam int DEPTH = 128;
  localparam int ACK_TIMEOUT = 16;
`ifdef NOISE_CDF_MONO_CHECK_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start, s_valid, done_wait;
  logic [63:0] s_data;
  logic        s_ready, load_mem, busy, cdf_ready, err;
  logic [7:0]  location, err_index;
  logic [63:0] mem_data;
  logic [1:0]  err_code;

  noise_cdf_loader #(
    .DEPTH       (DEPTH),
    .DATA_W      (64),
    .ADDR_W      (8),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .load_mem  (load_mem),
    .location  (location),
    .mem_data  (mem_data),
    .done_wait (done_wait),
    .busy      (busy),
    .cdf_ready (cdf_ready),
    .err       (err),
    .err_code  (err_code),
    .err_index (err_index)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] word(input int k);
    return (64'(k) << 40) + 64'(k * 7 + 3);
  endfunction

  // Behavioural model: what the loader must be doing, in terms of load progress
  bit          m_load = 0, m_wait_on = 0;
  int          m_pad = 0, m_wcnt = 0, m_cnt = 0;
  logic [63:0] m_last = '0;
  logic        e_load_mem = 0, e_cdf = 0, e_err = 0;
  logic [7:0]  e_loc = '0, e_idx = '0;
  logic [63:0] e_dat = '0;
  logic [1:0]  e_code = '0;

  task automatic model_step();
    if (!rstn) begin
      m_load = 0; m_wait_on = 0; m_pad = 0; m_wcnt = 0; m_cnt = 0; m_last = '0;
      e_load_mem = 0; e_cdf = 0; e_err = 0; e_loc = '0; e_idx = '0; e_dat = '0; e_code = '0;
    end else if (m_load) begin
      e_load_mem = 0;
      if (s_valid) begin
        if (MONO && m_cnt > 0 && s_data < m_last) begin
          m_load = 0; e_err = 1; e_code = 2'd1; e_idx = 8'(m_cnt);
        end else begin
          e_load_mem = 1; e_loc = 8'(m_cnt); e_dat = s_data; m_last = s_data;
          if (m_cnt == DEPTH - 1) begin m_load = 0; m_pad = 2; end
          else m_cnt++;
        end
      end
    end else if (m_pad > 0) begin
      e_load_mem = 1;
      m_pad--;
      if (m_pad == 0) begin m_wait_on = 1; m_wcnt = 0; end
    end else if (m_wait_on) begin
      e_load_mem = 0;
      if (done_wait) begin m_wait_on = 0; e_cdf = 1; end
      else if (m_wcnt == ACK_TIMEOUT - 1) begin m_wait_on = 0; e_err = 1; e_code = 2'd2; end
      else m_wcnt++;
    end else begin
      e_load_mem = 0;
      if (start) begin
        m_load = 1; m_cnt = 0; m_last = '0;
        e_err = 0; e_code = '0; e_idx = '0; e_cdf = 0;
      end
    end
  endtask

  logic [7:0]  wr_loc[$];
  logic [63:0] wr_dat[$];
  int cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, err_rise_cyc = 0;

  initial begin : compare
    logic [86:0] act, exp;
    logic prev_err;
    prev_err = 0;
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      if (rstn) begin
        act = {load_mem, location, mem_data, busy, cdf_ready, err, err_code, err_index, s_ready};
        exp = {e_load_mem, e_loc, e_dat, (m_load || m_pad > 0 || m_wait_on), e_cdf, e_err,
               e_code, e_idx, m_load};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_cmp @%0d: got %h want %h", cyc, act, exp);
        if (load_mem) begin
          if (wr_loc.size() == 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          wr_loc.push_back(location);
          wr_dat.push_back(mem_data);
        end
        if (err && !prev_err) err_rise_cyc = cyc;
        prev_err = err;
      end else begin
        prev_err = 0;
      end
    end
  end

  // Sends words 0..DEPTH-1; optional gaps, one bad word, reset after a word, or a stray start
  task automatic run_stream(input bit gaps, input int bad_at, input int rst_after, input int restart_at);
    int k, n;
    bit tog, acc, restarted;
    k = 0; n = 0; tog = 1; restarted = 0;
    wr_loc.delete(); wr_dat.delete();
    @(negedge clk);
    done_wait = 0; start = 1;
    @(negedge clk);
    start = 0;
    while (k < DEPTH && n < 2000) begin
      s_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      s_data = (k == bad_at) ? word(k - 1) - 64'd1 : word(k);
      if (k == restart_at && !restarted) begin start = 1; restarted = 1; end
      acc = s_valid && s_ready;
      @(negedge clk);
      n++;
      start = 0;
      if (acc) k++;
      if (rst_after >= 0 && k == rst_after + 1) begin
        s_valid = 0;
        rstn = 0;
        #1;
        chk("async_reset_outputs",
            {63'd0, load_mem, location, mem_data[31:0], busy, cdf_ready, err, err_code, err_index, s_ready} |
            {mem_data[63:32], 32'd0}, 64'd0);
        @(negedge clk);
        rstn = 1;
        return;
      end
      if (e_err) break;
    end
    s_valid = 0;
    if (n >= 2000) chk("stream_budget", 64'(n), 64'd0);
  endtask

  task automatic finish_ack(input bit give_ack, input int dly);
    int i;
    for (i = 0; i < 64 && !m_wait_on; i++) @(negedge clk);
    if (!m_wait_on) chk("reach_wait_ack", 64'd0, 64'd1);
    if (give_ack) begin
      repeat (dly) @(negedge clk);
      done_wait = 1;
    end
    for (i = 0; i < 40 && !(e_cdf || e_err); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0]  ref_loc[$];
  logic [63:0] ref_dat[$];

  initial begin : stim
    int bad;
    start = 0; s_valid = 0; s_data = '0; done_wait = 0;
    #1 rstn = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy_ready", {busy, cdf_ready, err, s_ready, load_mem}, 64'd0);
    chk("reset_regs", {location, err_index, err_code} | 64'(mem_data != 0), 64'd0);
    rstn = 1;

    // Full load, ack three cycles after WAIT_ACK entry
    run_stream(0, -1, -1, -1);
    finish_ack(1, 3);
    chk("t1_writes", 64'(wr_loc.size()), 64'd130);
    if (wr_loc.size() == 130) begin
      chk("t1_loc0", wr_loc[0], 64'd0);
      chk("t1_dat5", wr_dat[5], 64'h0000_0500_0000_0026);
      chk("t1_loc127", wr_loc[127], 64'd127);
      chk("t1_pad1", {wr_loc[128], wr_dat[128]}, {8'd127, word(127)});
      chk("t1_pad2", {wr_loc[129], wr_dat[129]}, {8'd127, word(127)});
    end
    chk("t1_span", 64'(last_wr_cyc - first_wr_cyc), 64'd129);
    chk("t1_cdf_ready", {cdf_ready, err}, 64'b10);
    ref_loc = wr_loc; ref_dat = wr_dat;

    // Same stream with s_valid low every other cycle
    run_stream(1, -1, -1, -1);
    finish_ack(1, 1);
    chk("t2_writes", 64'(wr_loc.size()), 64'd130);
    bad = 0;
    for (int i = 0; i < 130 && i < wr_loc.size(); i++)
      if (wr_loc[i] !== ref_loc[i] || wr_dat[i] !== ref_dat[i]) bad++;
    chk("t2_same_writes", 64'(bad), 64'd0);
    chk("t2_span_gapped", 64'(last_wr_cyc - first_wr_cyc > 129), 64'd1);

    // Word 40 below word 39
    run_stream(0, 40, -1, -1);
    if (MONO) begin
      repeat (2) @(negedge clk);
      chk("t3_err_flags", {err, err_code, err_index}, {1'b1, 2'd1, 8'd40});
      chk("t3_s_ready", s_ready, 64'd0);
      chk("t3_writes", 64'(wr_loc.size()), 64'd40);
    end else begin
      finish_ack(1, 2);
      chk("t3_unchecked_writes", 64'(wr_loc.size()), 64'd130);
      if (wr_dat.size() > 40) chk("t3_bad_written", wr_dat[40], word(39) - 64'd1);
      chk("t3_no_err", {err, err_code, err_index}, 64'd0);
    end

    // No acknowledge: timeout 16 cycles after WAIT_ACK entry
    run_stream(0, -1, -1, -1);
    finish_ack(0, 0);
    chk("t4_timeout_code", {err, err_code, busy}, {1'b1, 2'd2, 1'b0});
    chk("t4_timeout_delay", 64'(err_rise_cyc - last_wr_cyc), 64'd16);
    run_stream(0, -1, -1, -1);
    finish_ack(1, 0);
    chk("t4_reload_ok", {cdf_ready, err, err_code}, 64'b1000);

    // Reset after word 60, then reload from index 0
    run_stream(0, -1, 60, -1);
    run_stream(0, -1, -1, -1);
    finish_ack(1, 3);
    chk("t5_writes", 64'(wr_loc.size()), 64'd130);
    if (wr_loc.size() > 0) chk("t5_first_loc", wr_loc[0], 64'd0);
    chk("t5_cdf_ready", cdf_ready, 64'd1);

    // start pulsed during LOAD must be ignored
    run_stream(0, -1, -1, 10);
    finish_ack(1, 2);
    chk("t6_writes", 64'(wr_loc.size()), 64'd130);
    bad = 0;
    for (int i = 0; i < 128 && i < wr_loc.size(); i++)
      if (wr_loc[i] !== 8'(i)) bad++;
    chk("t6_locations_seq", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
